full_adder: RTL and testbench



---
 rtl/full_adder.sv | 125 ++++++++++++
 tb/tb_full_adder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// Purpose : registered full adder {cout,sum} = a + b + cin, carry chain split into STAGES slices.
// Latency : STAGES cycles (STAGES=1 -> result visible the cycle after operands are sampled).
// Backpressure: none; out_valid is a fixed-latency copy of in_valid. Option macro: FULL_ADDER_OVF_EN adds ovf.
module full_adder #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Bits added per pipeline stage.
  localparam int SL = (STAGES > 0) ? (WIDTH / STAGES) : 1;

  // Reject configurations the slicing cannot represent.
  if ((WIDTH < 1) || (WIDTH > 64) || (STAGES < 1) || (STAGES > WIDTH) ||
      ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $error("full_adder: illegal WIDTH/STAGES combination");
  end

  // Stage k consumes the low SL bits of the operands it receives, forwards the
  // still-unconsumed upper operand bits, and appends its sum slice above the
  // sum bits completed by earlier stages. Only the carry crosses stage borders.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IW = WIDTH - k * SL;  // operand bits still to be added
    localparam int DW = (k + 1) * SL;    // sum bits complete after this stage

    logic          w_vld_in;
    logic [IW-1:0] w_a_in;
    logic [IW-1:0] w_b_in;
    logic          w_c_in;
    logic [SL:0]   w_slice;
    logic [DW-1:0] w_sum_nxt;

    logic          r_vld;
    logic          r_carry;
    logic [DW-1:0] r_sum;

    if (k == 0) begin : g_src
      assign w_vld_in  = in_valid;
      assign w_a_in    = a;
      assign w_b_in    = b;
      assign w_c_in    = cin;
      assign w_sum_nxt = w_slice[SL-1:0];
    end else begin : g_src
      assign w_vld_in  = g_stage[k-1].r_vld;
      assign w_a_in    = g_stage[k-1].g_fwd.r_a;
      assign w_b_in    = g_stage[k-1].g_fwd.r_b;
      assign w_c_in    = g_stage[k-1].r_carry;
      assign w_sum_nxt = {w_slice[SL-1:0], g_stage[k-1].r_sum};
    end

    // Slice add at SL+1 bits so the slice carry-out is kept.
    assign w_slice = {1'b0, w_a_in[SL-1:0]} + {1'b0, w_b_in[SL-1:0]} + {{SL{1'b0}}, w_c_in};

    // Valid always advances; carry and completed sum load only on a valid slot,
    // so idle-cycle operand garbage never reaches the held outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld   <= 1'b0;
        r_carry <= 1'b0;
        r_sum   <= '0;
      end else begin
        r_vld <= w_vld_in;
        if (w_vld_in) begin
          r_carry <= w_slice[SL];
          r_sum   <= w_sum_nxt;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [IW-SL-1:0] r_a;
      logic [IW-SL-1:0] r_b;

      // Delay the operand bits later stages still have to add.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_vld_in) begin
          r_a <= w_a_in[IW-1:SL];
          r_b <= w_b_in[IW-1:SL];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_vld;
  assign sum       = g_stage[STAGES-1].r_sum;
  assign cout      = g_stage[STAGES-1].r_carry;

`ifdef FULL_ADDER_OVF_EN
  // Carry into the MSB is recovered as a ^ b ^ s at the MSB; overflow is that
  // carry XOR the carry out of the MSB.
  logic w_ovf_nxt;
  logic r_ovf;

  assign w_ovf_nxt = g_stage[STAGES-1].w_a_in[SL-1] ^ g_stage[STAGES-1].w_b_in[SL-1] ^
                     g_stage[STAGES-1].w_slice[SL-1] ^ g_stage[STAGES-1].w_slice[SL];

  // Overflow flag registered alongside the final sum slice and held the same way.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (g_stage[STAGES-1].w_vld_in) begin
      r_ovf <= w_ovf_nxt;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: three instances (W1/S1, W8/S4, W8/S2) driven with directed
// and random traffic; an arithmetic reference with a result queue predicts every output.
module tb_full_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iv0, iv1, iv2;
  logic [0:0] a0, b0;
  logic [7:0] a1, b1, a2, b2;
  logic       c0, c1, c2;
  logic       ov0, ov1, ov2;
  logic [0:0] s0;
  logic [7:0] s1, s2;
  logic       co0, co1, co2;
  logic       of0, of1, of2;

`ifdef FULL_ADDER_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
  assign of0 = 1'b0;
  assign of1 = 1'b0;
  assign of2 = 1'b0;
`endif

  full_adder #(.WIDTH(1), .STAGES(1)) u_fa0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .a(a0), .b(b0), .cin(c0),
    .out_valid(ov0), .sum(s0), .cout(co0)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(of0)
`endif
  );

  full_adder #(.WIDTH(8), .STAGES(4)) u_fa1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .cin(c1),
    .out_valid(ov1), .sum(s1), .cout(co1)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(of1)
`endif
  );

  full_adder #(.WIDTH(8), .STAGES(2)) u_fa2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .a(a2), .b(b2), .cin(c2),
    .out_valid(ov2), .sum(s2), .cout(co2)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(of2)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  int W_ [3] = '{1, 8, 8};
  int S_ [3] = '{1, 4, 2};
  logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  typedef struct {
    int         id;
    int         due;
    logic [9:0] val;  // {ovf, cout, sum[7:0]}
  } ent_t;

  ent_t       q[$];
  logic [9:0] held [3];
  int         cyc   = 0;
  bit         armed = 1'b0;

  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain unsigned and signed integer arithmetic at width w.
  function automatic logic [9:0] model(input int w, input logic [7:0] x, input logic [7:0] y,
                                       input logic c);
    longint mask, ux, uy, tot, sx, sy, st, lo, hi;
    logic [9:0] r;
    mask = (64'sd1 <<< w) - 1;
    ux   = longint'(x) & mask;
    uy   = longint'(y) & mask;
    tot  = ux + uy + longint'(c);
    sx   = (ux >= (64'sd1 <<< (w - 1))) ? ux - (64'sd1 <<< w) : ux;
    sy   = (uy >= (64'sd1 <<< (w - 1))) ? uy - (64'sd1 <<< w) : uy;
    st   = sx + sy + longint'(c);
    lo   = -(64'sd1 <<< (w - 1));
    hi   = (64'sd1 <<< (w - 1)) - 1;
    r[9] = (st < lo) || (st > hi);
    r[8] = (tot >>> w) != 0;
    r[7:0] = 8'(tot & mask);
    return r;
  endfunction

  function automatic logic [10:0] expv(input logic v, input logic [9:0] m);
    return {v, m[9] & OVF, m[8:0]};
  endfunction

  function automatic logic [10:0] obs(input int d);
    case (d)
      0:       return {ov0, of0, co0, 7'b0, s0};
      1:       return {ov1, of1, co1, s1};
      default: return {ov2, of2, co2, s2};
    endcase
  endfunction

  function automatic logic get_iv(input int d);
    case (d)
      0:       return iv0;
      1:       return iv1;
      default: return iv2;
    endcase
  endfunction

  function automatic logic [16:0] get_in(input int d);
    case (d)
      0:       return {7'b0, a0, 7'b0, b0, c0};
      1:       return {a1, b1, c1};
      default: return {a2, b2, c2};
    endcase
  endfunction

  task automatic idle_all();
    iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    a0 = 1'($urandom); b0 = 1'($urandom); c0 = 1'($urandom);
    a1 = 8'($urandom); b1 = 8'($urandom); c1 = 1'($urandom);
    a2 = 8'($urandom); b2 = 8'($urandom); c2 = 1'($urandom);
  endtask

  task automatic set(input int d, input logic [7:0] x, input logic [7:0] y, input logic c);
    case (d)
      0:       begin iv0 = 1'b1; a0 = x[0]; b0 = y[0]; c0 = c; end
      1:       begin iv1 = 1'b1; a1 = x;    b1 = y;    c1 = c; end
      default: begin iv2 = 1'b1; a2 = x;    b2 = y;    c2 = c; end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: at every edge, reset flushes everything; otherwise accepted operands
  // are queued with the edge number after which their result must be visible.
  initial begin
    ent_t       e;
    logic [16:0] in;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        q.delete();
        for (int d = 0; d < 3; d++) held[d] = '0;
        armed = 1'b1;
      end else begin
        for (int d = 0; d < 3; d++) begin
          if (get_iv(d)) begin
            in    = get_in(d);
            e.id  = d;
            e.due = cyc + S_[d] - 1;
            e.val = model(W_[d], in[16:9], in[8:1], in[0]);
            q.push_back(e);
          end
        end
      end
    end
  end

  // Compare every instance on every cycle, mid-cycle.
  initial begin
    int idx;
    forever begin
      @(negedge clk);
      if (armed) begin
        for (int d = 0; d < 3; d++) begin
          idx = -1;
          for (int i = 0; i < q.size(); i++) begin
            if (q[i].id == d) begin
              idx = i;
              break;
            end
          end
          if (idx >= 0 && q[idx].due == cyc) begin
            chk($sformatf("dut%0d_res_cyc%0d", d, cyc), obs(d), expv(1'b1, q[idx].val));
            held[d] = q[idx].val;
            q.delete(idx);
          end else begin
            chk($sformatf("dut%0d_idle_cyc%0d", d, cyc), obs(d), expv(1'b0, held[d]));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle_all();

    // Pin the reference to hand-computed results.
    chk("pin_w1_111", {1'b0, model(1, 8'h01, 8'h01, 1'b1)}, 11'h101);
    chk("pin_w1_001", {1'b0, model(1, 8'h00, 8'h00, 1'b1)}, 11'h201);
    chk("pin_ff_00_1", {1'b0, model(8, 8'hFF, 8'h00, 1'b1)}, 11'h100);
    chk("pin_ff_ff_1", {1'b0, model(8, 8'hFF, 8'hFF, 1'b1)}, 11'h1FF);
    chk("pin_7f_01_0", {1'b0, model(8, 8'h7F, 8'h01, 1'b0)}, 11'h280);
    chk("pin_80_80_0", {1'b0, model(8, 8'h80, 8'h80, 1'b0)}, 11'h300);

    repeat (3) step();
    chk("reset_dut1", {ov1, co1, s1}, 10'h000);
    rst = 1'b0;

    // WIDTH=1 truth table, one vector per cycle, visible the next cycle.
    for (int i = 0; i < 8; i++) begin
      idle_all();
      set(0, 8'((i >> 2) & 1), 8'((i >> 1) & 1), 1'(i & 1));
      step();
      chk($sformatf("tt_%0d", i), {8'b0, ov0, co0, s0}, {8'b0, 1'b1, tt[i]});
    end

    // WIDTH=8 STAGES=4 boundary vectors, back to back.
    idle_all(); set(1, 8'hFF, 8'h00, 1'b1); step();
    idle_all(); set(1, 8'hFF, 8'hFF, 1'b1); step();
    idle_all(); set(1, 8'h00, 8'h00, 1'b0); step();
    idle_all(); set(1, 8'h7F, 8'h01, 1'b0); step();
    chk("s4_ff_00_1", {ov1, co1, s1}, {1'b1, 1'b1, 8'h00});
    idle_all(); set(1, 8'h80, 8'h80, 1'b0); step();
    chk("s4_ff_ff_1", {ov1, co1, s1}, {1'b1, 1'b1, 8'hFF});
    idle_all(); step();
    chk("s4_00_00_0", {ov1, co1, s1}, {1'b1, 1'b0, 8'h00});
    step();
    chk("s4_7f_01_0", {ov1, co1, s1}, {1'b1, 1'b0, 8'h80});
    if (OVF) chk("s4_7f_01_ovf", {10'b0, of1}, 11'h001);
    step();
    chk("s4_80_80_0", {ov1, co1, s1}, {1'b1, 1'b1, 8'h00});
    if (OVF) chk("s4_80_80_ovf", {10'b0, of1}, 11'h001);
    repeat (3) step();

    // Reset with two operations in flight.
    idle_all(); set(1, 8'h12, 8'h34, 1'b0); step();
    idle_all(); set(1, 8'h56, 8'h78, 1'b1); step();
    idle_all(); rst = 1'b1; step();
    rst = 1'b0;
    chk("rst_flush", {ov1, co1, s1}, 10'h000);
    repeat (6) step();

    // Valid pattern 1,0,1 on the STAGES=2 instance.
    idle_all(); set(2, 8'd3, 8'd4, 1'b0); step();
    idle_all(); step();
    chk("p101_first", {ov2, co2, s2}, {1'b1, 1'b0, 8'd7});
    set(2, 8'd1, 8'd1, 1'b1); step();
    chk("p101_hold", {ov2, co2, s2}, {1'b0, 1'b0, 8'd7});
    idle_all(); step();
    chk("p101_second", {ov2, co2, s2}, {1'b1, 1'b0, 8'd3});

    // Ten back-to-back random vectors on the STAGES=2 instance.
    for (int i = 0; i < 10; i++) begin
      idle_all();
      set(2, 8'($urandom), 8'($urandom), 1'($urandom));
      step();
    end
    idle_all();
    repeat (4) step();

    // Mixed random traffic on all instances with occasional resets.
    for (int i = 0; i < 400; i++) begin
      idle_all();
      for (int d = 0; d < 3; d++)
        if ($urandom_range(0, 3) != 0) set(d, 8'($urandom), 8'($urandom), 1'($urandom));
      rst = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 1'b0;
    idle_all();
    repeat (8) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
